mbr_buffer: RTL and testbench

Parametrised memory buffer register with a req/ack memory handshake, bounded wait and load-priority resolution. It sits between main memory and the datapath registers (PC, MAR, IR, BR, MR, ACC) and is driven by the 32-bit microcontrol word. It captures memory read data, drives write data, and fans the buffered word out to the datapath, while stalling the controller via `busy` during memory transactions.

---
 rtl/mbr_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_mbr_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbr_buffer.sv
// mbr_buffer -- memory buffer register between main memory and the datapath.
//
// Captures memory read data and drives memory write data through a level
// req/ack handshake with a bounded wait. In IDLE it loads the buffer from
// ACC, MR or PC, and copies the buffer out to PC, MAR, IR and BR. While a
// memory transaction is outstanding, busy stalls the controller and the
// control word is ignored.
//
// Control word bits used:
//   1 PC load, 3 ->PC, 4 ->IR, 5 read, 6 ->BR, 8 ->MAR, 11 ACC load,
//   12 store, 15 MR load
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   control_signal[31:0]              microcontrol word
//   data_from_memory, mem_rd_ack      read data and read completion
//   mem_wr_ack                        write completion
//   data_from_pc/mr/acc               datapath load sources
//   mem_rd_req, mem_wr_req            level requests, held until ack/timeout
//   data_to_memory                    write data, stable while mem_wr_req
//   data_to_pc/mar/ir/br              registered buffer transfers
//   busy                              high in any non-IDLE state
//   timeout_err                       sticky, transaction exceeded MAX_WAIT
//   conflict_err                      sticky load conflict flag
//
// Build option: define MBR_LOAD_CONFLICT_EN to build load-conflict
// detection; otherwise conflict_err is tied to 0.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | accepts commands, loads and transfers
// ST_RD_WAIT | mem_rd_req high, waiting for mem_rd_ack or timeout
// ST_WR_WAIT | mem_wr_req high, waiting for mem_wr_ack or timeout
module mbr_buffer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int OP_W     = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       control_signal,
    input  logic [DATA_W-1:0] data_from_memory,
    input  logic              mem_rd_ack,
    input  logic              mem_wr_ack,
    input  logic [ADDR_W-1:0] data_from_pc,
    input  logic [DATA_W-1:0] data_from_mr,
    input  logic [DATA_W-1:0] data_from_acc,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [DATA_W-1:0] data_to_memory,
    output logic [ADDR_W-1:0] data_to_pc,
    output logic [ADDR_W-1:0] data_to_mar,
    output logic [OP_W-1:0]   data_to_ir,
    output logic [DATA_W-1:0] data_to_br,
    output logic              busy,
    output logic              timeout_err,
    output logic              conflict_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_buf, w_buf_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_rd_req, w_rd_req_nxt;
    logic              r_wr_req, w_wr_req_nxt;
    logic [DATA_W-1:0] r_dmem, w_dmem_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_mar, w_mar_nxt;
    logic [OP_W-1:0]   r_ir, w_ir_nxt;
    logic [DATA_W-1:0] r_br, w_br_nxt;
    logic              r_tmo, w_tmo_nxt;
    logic              w_cnt_last;
    logic              w_unused_ctrl;

    // The MAX_WAIT-th edge without ack is the one where the count of
    // previous ack-less edges has reached MAX_WAIT-1.
    assign w_cnt_last = (r_cnt == CNT_W'(MAX_WAIT - 1));

    assign w_unused_ctrl = ^{control_signal[31:16], control_signal[14:13],
                             control_signal[10:9], control_signal[7],
                             control_signal[2], control_signal[0]};

    always_comb begin
        w_state_nxt  = r_state;
        w_buf_nxt    = r_buf;
        w_cnt_nxt    = r_cnt;
        w_rd_req_nxt = r_rd_req;
        w_wr_req_nxt = r_wr_req;
        w_dmem_nxt   = r_dmem;
        w_pc_nxt     = r_pc;
        w_mar_nxt    = r_mar;
        w_ir_nxt     = r_ir;
        w_br_nxt     = r_br;
        w_tmo_nxt    = r_tmo;
        case (r_state)
            ST_IDLE: begin
                // Store and all transfers see the buffer before this edge's load.
                if (control_signal[12]) begin
                    w_dmem_nxt   = r_buf;
                    w_wr_req_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_WR_WAIT;
                end else if (control_signal[5]) begin
                    w_rd_req_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_RD_WAIT;
                end
                if (control_signal[11])
                    w_buf_nxt = data_from_acc;
                else if (control_signal[15])
                    w_buf_nxt = data_from_mr;
                else if (control_signal[1])
                    w_buf_nxt[ADDR_W-1:0] = data_from_pc;
                if (control_signal[3]) w_pc_nxt  = r_buf[ADDR_W-1:0];
                if (control_signal[8]) w_mar_nxt = r_buf[ADDR_W-1:0];
                if (control_signal[4]) w_ir_nxt  = r_buf[DATA_W-1 -: OP_W];
                if (control_signal[6]) w_br_nxt  = r_buf;
            end
            ST_RD_WAIT: begin
                if (mem_rd_ack) begin
                    w_buf_nxt    = data_from_memory;
                    w_rd_req_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (w_cnt_last) begin
                    w_rd_req_nxt = 1'b0;
                    w_tmo_nxt    = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WR_WAIT: begin
                if (mem_wr_ack) begin
                    w_wr_req_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (w_cnt_last) begin
                    w_wr_req_nxt = 1'b0;
                    w_tmo_nxt    = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_rd_req_nxt = 1'b0;
                w_wr_req_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_dmem   <= '0;
            r_pc     <= '0;
            r_mar    <= '0;
            r_ir     <= '0;
            r_br     <= '0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_buf    <= w_buf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rd_req <= w_rd_req_nxt;
            r_wr_req <= w_wr_req_nxt;
            r_dmem   <= w_dmem_nxt;
            r_pc     <= w_pc_nxt;
            r_mar    <= w_mar_nxt;
            r_ir     <= w_ir_nxt;
            r_br     <= w_br_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

`ifdef MBR_LOAD_CONFLICT_EN
    logic r_conflict;
    logic w_conflict_hit;

    // Two or more internal loads at once, or read and store together.
    assign w_conflict_hit = (r_state == ST_IDLE) &&
        ((control_signal[11] & control_signal[15]) |
         (control_signal[11] & control_signal[1])  |
         (control_signal[15] & control_signal[1])  |
         (control_signal[5]  & control_signal[12]));

    always_ff @(posedge clk) begin
        if (rst)
            r_conflict <= 1'b0;
        else if (w_conflict_hit)
            r_conflict <= 1'b1;
    end

    assign conflict_err = r_conflict;
`else
    assign conflict_err = 1'b0;
`endif

    assign mem_rd_req     = r_rd_req;
    assign mem_wr_req     = r_wr_req;
    assign data_to_memory = r_dmem;
    assign data_to_pc     = r_pc;
    assign data_to_mar    = r_mar;
    assign data_to_ir     = r_ir;
    assign data_to_br     = r_br;
    assign busy           = (r_state != ST_IDLE);
    assign timeout_err    = r_tmo;

endmodule

// File: tb/tb_mbr_buffer.sv
module tb_mbr_buffer;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] control_signal = '0;
    logic [15:0] data_from_memory = '0;
    logic        mem_rd_ack = 1'b0;
    logic        mem_wr_ack = 1'b0;
    logic [7:0]  data_from_pc = '0;
    logic [15:0] data_from_mr = '0;
    logic [15:0] data_from_acc = '0;
    logic        mem_rd_req, mem_wr_req;
    logic [15:0] data_to_memory;
    logic [7:0]  data_to_pc, data_to_mar, data_to_ir;
    logic [15:0] data_to_br;
    logic        busy, timeout_err, conflict_err;

    mbr_buffer #(.DATA_W(16), .ADDR_W(8), .OP_W(8), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .control_signal(control_signal),
        .data_from_memory(data_from_memory), .mem_rd_ack(mem_rd_ack),
        .mem_wr_ack(mem_wr_ack), .data_from_pc(data_from_pc),
        .data_from_mr(data_from_mr), .data_from_acc(data_from_acc),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .data_to_memory(data_to_memory), .data_to_pc(data_to_pc),
        .data_to_mar(data_to_mar), .data_to_ir(data_to_ir),
        .data_to_br(data_to_br), .busy(busy), .timeout_err(timeout_err),
        .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        rd;
        logic        wr;
        logic [15:0] dmem;
        logic [7:0]  pc;
        logic [7:0]  mar;
        logic [7:0]  ir;
        logic [15:0] br;
        logic        tmo;
        logic        cfl;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: pending transaction kind (0 none, 1 read, 2 write),
    // number of ack-less wait edges so far, buffer word, expected outputs.
    int          m_kind = 0;
    int          m_waited = 0;
    logic [15:0] m_buf = '0;
    exp_t        m_exp = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_edge();
        logic [15:0] old;
        if (rst) begin
            m_kind = 0; m_waited = 0; m_buf = '0; m_exp = '0;
        end else if (m_kind == 0) begin
            old = m_buf;
            if (control_signal[3]) m_exp.pc  = old[7:0];
            if (control_signal[8]) m_exp.mar = old[7:0];
            if (control_signal[4]) m_exp.ir  = old[15:8];
            if (control_signal[6]) m_exp.br  = old;
            if (control_signal[12]) begin
                m_exp.dmem = old; m_kind = 2; m_waited = 0;
            end else if (control_signal[5]) begin
                m_kind = 1; m_waited = 0;
            end
            if (control_signal[11])      m_buf = data_from_acc;
            else if (control_signal[15]) m_buf = data_from_mr;
            else if (control_signal[1])  m_buf = {m_buf[15:8], data_from_pc};
`ifdef MBR_LOAD_CONFLICT_EN
            if ($countones({control_signal[11], control_signal[15], control_signal[1]}) >= 2 ||
                (control_signal[5] && control_signal[12]))
                m_exp.cfl = 1'b1;
`endif
        end else begin
            if ((m_kind == 1 && mem_rd_ack) || (m_kind == 2 && mem_wr_ack)) begin
                if (m_kind == 1) m_buf = data_from_memory;
                m_kind = 0;
            end else begin
                m_waited++;
                if (m_waited == MW) begin
                    m_kind = 0;
                    m_exp.tmo = 1'b1;
                end
            end
        end
        m_exp.busy = (m_kind != 0);
        m_exp.rd   = (m_kind == 1);
        m_exp.wr   = (m_kind == 2);
    endtask

    task automatic drive(input logic r, input logic [31:0] c, input logic ra,
                         input logic wa, input logic [15:0] md);
        rst = r; control_signal = c; mem_rd_ack = ra; mem_wr_ack = wa;
        data_from_memory = md;
        model_edge();
        sb_q.push_back(m_exp);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each negedge pops the expectation for the edge just taken.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk("busy", 32'(busy), 32'(x.busy));
                chk("mem_rd_req", 32'(mem_rd_req), 32'(x.rd));
                chk("mem_wr_req", 32'(mem_wr_req), 32'(x.wr));
                chk("data_to_memory", 32'(data_to_memory), 32'(x.dmem));
                chk("data_to_pc", 32'(data_to_pc), 32'(x.pc));
                chk("data_to_mar", 32'(data_to_mar), 32'(x.mar));
                chk("data_to_ir", 32'(data_to_ir), 32'(x.ir));
                chk("data_to_br", 32'(data_to_br), 32'(x.br));
                chk("timeout_err", 32'(timeout_err), 32'(x.tmo));
                chk("conflict_err", 32'(conflict_err), 32'(x.cfl));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] B1 = 32'h2, B3 = 32'h8, B4 = 32'h10, B5 = 32'h20,
                            B6 = 32'h40, B8 = 32'h100, B11 = 32'h800,
                            B12 = 32'h1000, B15 = 32'h8000;

    initial begin
        int busy_cnt;

        // Reset with every input nonzero
        data_from_pc = 8'hFF; data_from_mr = 16'hFFFF; data_from_acc = 16'hFFFF;
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 16'hFFFF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_req", 32'(mem_rd_req), 0);
        chk("rst_wr_req", 32'(mem_wr_req), 0);
        chk("rst_br", 32'(data_to_br), 0);
        chk("rst_dmem", 32'(data_to_memory), 0);
        drive(1'b0, 0, 1'b0, 1'b0, 16'h0);

        // Read, ack at the third wait edge, then IR/BR transfer
        busy_cnt = 0;
        drive(1'b0, B5, 1'b0, 1'b0, 16'h0);
        busy_cnt += int'(busy);
        drive(1'b0, 0, 1'b0, 1'b0, 16'h0);
        busy_cnt += int'(busy);
        drive(1'b0, 0, 1'b0, 1'b0, 16'h0);
        busy_cnt += int'(busy);
        drive(1'b0, 0, 1'b1, 1'b0, 16'hA53C);
        busy_cnt += int'(busy);
        chk("rd_busy_cycles", 32'(busy_cnt), 3);
        drive(1'b0, B4 | B6, 1'b0, 1'b0, 16'h0);
        chk("rd_ir", 32'(data_to_ir), 32'h A5);
        chk("rd_br", 32'(data_to_br), 32'hA53C);

        // ACC load then store
        data_from_acc = 16'h1234;
        drive(1'b0, B11, 1'b0, 1'b0, 16'h0);
        drive(1'b0, B12, 1'b0, 1'b0, 16'h0);
        chk("st_req", 32'(mem_wr_req), 1);
        chk("st_data", 32'(data_to_memory), 32'h1234);
        drive(1'b0, 0, 1'b1, 1'b0, 16'h0);
        chk("st_rd_ack_ignored", 32'(mem_wr_req), 1);
        drive(1'b0, 0, 1'b0, 1'b1, 16'h0);
        chk("st_done", 32'(mem_wr_req), 0);

        // Load priority, then PC-only load keeps the upper byte
        data_from_acc = 16'h00FF; data_from_mr = 16'h0F0F; data_from_pc = 8'h77;
        drive(1'b0, B11 | B15 | B1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, B6, 1'b0, 1'b0, 16'h0);
        chk("prio_br", 32'(data_to_br), 32'h00FF);
`ifdef MBR_LOAD_CONFLICT_EN
        chk("prio_conflict", 32'(conflict_err), 1);
`else
        chk("prio_conflict", 32'(conflict_err), 0);
`endif
        drive(1'b0, B1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, B6 | B3 | B8, 1'b0, 1'b0, 16'h0);
        chk("pc_load_br", 32'(data_to_br), 32'h0077);
        chk("pc_load_mar", 32'(data_to_mar), 32'h77);

        // Timeout: no ack for MW wait edges
        drive(1'b0, B5, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i < MW; i++) drive(1'b0, 0, 1'b0, 1'b1, 16'h0);
        chk("tmo_req_before", 32'(mem_rd_req), 1);
        drive(1'b0, 0, 1'b0, 1'b0, 16'h0);
        chk("tmo_req_after", 32'(mem_rd_req), 0);
        chk("tmo_err", 32'(timeout_err), 1);
        drive(1'b0, B6, 1'b0, 1'b0, 16'h0);
        chk("tmo_buf_kept", 32'(data_to_br), 32'h0077);
        drive(1'b0, B5, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 0, 1'b1, 1'b0, 16'hBEEF);
        drive(1'b0, B6, 1'b0, 1'b0, 16'h0);
        chk("tmo_next_read", 32'(data_to_br), 32'hBEEF);

        // Reset in the middle of a read
        drive(1'b1, 0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, B5, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 0, 1'b0, 1'b0, 16'h0);
        chk("rstmid_req", 32'(mem_rd_req), 0);
        chk("rstmid_busy", 32'(busy), 0);
        drive(1'b0, 0, 1'b1, 1'b0, 16'h5555);
        drive(1'b0, B6, 1'b0, 1'b0, 16'h0);
        chk("rstmid_ack_ignored", 32'(data_to_br), 0);
        chk("rstmid_tmo", 32'(timeout_err), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            data_from_pc  = 8'($urandom);
            data_from_mr  = 16'($urandom);
            data_from_acc = 16'($urandom);
            drive(($urandom_range(0, 199) == 0), $urandom & $urandom,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  16'($urandom));
        end
        drive(1'b0, 0, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
